unary_stream_gen: RTL and testbench
===================================

Name: unary_stream_gen

Overview:
- Upstream stage of the unary adder. Converts a binary operand into a unary (rate-coded) bitstream over a frame of 2^WIDTH enabled cycles.
- The serial output feeds one adder input (A or B) directly. Two instances drive A and B in lock-step.
- Two coding modes:
  - Thermometer: leading ones.
  - Spread: ones interleaved by bit-reversed counter compare.

Parameters:
- WIDTH, 14, frame counter width; frame length = 2^WIDTH enabled cycles.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  stream enable; frame advances only on cycles with en=1.
- load  in  1  request to start a frame with din; accepted when load & ready.
- din  in  WIDTH+1  operand; legal range 0..2^WIDTH; larger values saturate.
- mode  in  1  0 = thermometer, 1 = spread; sampled at load acceptance.
- ready  out  1  high when a load can be accepted.
- dout  out  1  unary bit, registered.
- dout_valid  out  1  high when dout carries a frame bit.
- frame_start  out  1  one-cycle pulse coincident with the first valid bit of a frame.
- frame_done  out  1  one-cycle pulse coincident with the last valid bit of a frame.
- sat  out  1  sticky per frame: loaded din exceeded 2^WIDTH.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cnt=0; value=0.
  - dout=0, dout_valid=0, frame_start=0, frame_done=0, sat=0.
  - ready=1 one cycle after release.
- States: IDLE, RUN.
- IDLE:
  - ready=1.
  - On load=1, capture value = min(din, 2^WIDTH), mode_q = mode, sat = (din > 2^WIDTH), cnt=0, then go to RUN.
- RUN:
  - ready=0, except in the final enabled cycle (cnt = 2^WIDTH-1 and en=1).
  - Each cycle with en=1:
    - Registered output: dout <= (mode_q ? bitrev(cnt) : cnt) < value, using a WIDTH+1-bit unsigned compare.
    - dout_valid <= 1; cnt <= cnt+1 (wraps to 0).
  - en=0:
    - dout <= 0, dout_valid <= 0; cnt holds.
    - Downstream sees no spurious ones during stalls.
- Latency: the bit for count k appears on dout one cycle after the enabled edge that evaluates k.
- Frame pulses:
  - frame_start asserts with the dout_valid for cnt=0.
  - frame_done asserts with the dout_valid for cnt=2^WIDTH-1.
- End of frame, on the enabled cycle with cnt = 2^WIDTH-1:
  - If load=1 in that cycle: accept back-to-back. Reload value/mode_q/sat, cnt=0, stay in RUN, no gap cycle.
  - Otherwise go to IDLE. dout/dout_valid return to 0 the cycle after the last bit.
- load while RUN and not in the final cycle: ignored; no state change.
- Counting guarantee: over one full frame, the number of dout=1 bits equals value exactly in both modes.
  - value=0 gives all zeros.
  - value=2^WIDTH gives all ones.
- Async reset mid-frame: immediate abort, all outputs 0. No frame_done for the aborted frame.
- mode and din changes during RUN have no effect until the next accepted load.

Decomposition:
- Package unary_pkg:
  - WIDTH default constant.
  - State enum {IDLE, RUN}.
  - Mode constants MODE_THERM=0, MODE_SPREAD=1.
  - bitrev function over WIDTH bits.
- One sub-module, unary_frame_counter, owns:
  - The WIDTH-bit enabled counter.
  - Terminal-count flag (cnt = 2^WIDTH-1 & en).
  - First-cycle flag.
- The parent holds the FSM, operand register, comparator and output registers.

Test Plan (WIDTH=4 unless noted, en=1 continuously):
- Thermometer: load din=5, mode=0 -> dout=1 for the first 5 valid bits, then 11 zeros. frame_start on bit 0, frame_done on bit 15, ready back high after.
- Spread: load din=4, mode=1 -> dout=1 exactly at cnt 0,4,8,12. Total ones = 4.
- Saturation and extremes:
  - din=20 -> 16 ones, sat=1.
  - din=0 -> 16 zeros, sat=0.
  - din=16 -> 16 ones, sat=0.
- Stall: din=3, mode=0, en deasserted for 3 cycles after the 2nd valid bit -> dout=0 and dout_valid=0 during the stall. Frame resumes at cnt=2. Ones total 3; frame_done delayed by 3 cycles.
- Back-to-back: load din=7 then hold load=1 with din=2 through the final cycle -> second frame's bit 0 immediately follows the first frame's bit 15. Counts 7 then 2.
- Reset mid-frame and full width:
  - Assert rst_n=0 at cnt=9 -> outputs 0 asynchronously, no frame_done, ready=1 after release.
  - WIDTH=14: two instances (din=4096, din=8193) feed the adder -> 4096 and 8193 ones per 16384-cycle frame.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary bitstream generator.
package unary_pkg;

  localparam int unsigned DEFAULT_WIDTH = 14;
  localparam int unsigned MAX_W         = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_THERM  = 1'b0;
  localparam logic MODE_SPREAD = 1'b1;

  // Reverse the low w bits of x; result is right-aligned.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int unsigned w);
    logic [MAX_W-1:0] full;
    for (int i = 0; i < MAX_W; i++) full[i] = x[MAX_W-1-i];
    return full >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/unary_frame_counter.sv
// Frame position counter with terminal-count and first-cycle flags.
module unary_frame_counter #(
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             term_c,
  output logic             first_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + WIDTH'(1);
  end

  assign term_c  = inc & (cnt == {WIDTH{1'b1}});
  assign first_c = inc & (cnt == '0);

endmodule

// File: rtl/unary_stream_gen.sv
// Binary operand to rate-coded unary bitstream, one frame of 2^WIDTH enabled cycles.
module unary_stream_gen
  import unary_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           load,
  input  logic [WIDTH:0] din,
  input  logic           mode,
  output logic           ready,
  output logic           dout,
  output logic           dout_valid,
  output logic           frame_start,
  output logic           frame_done,
  output logic           sat
);

  localparam int unsigned VW = WIDTH + 1;
  localparam logic [VW-1:0] FULL = {1'b1, {WIDTH{1'b0}}};

  state_e          state_q, state_d;
  logic [VW-1:0]   value_q, value_d;
  logic            mode_q, mode_d;
  logic            sat_d, dout_d, valid_d, start_d, done_d;
  logic            armed_q;
  logic [WIDTH-1:0] cnt, sel;
  logic            inc, clr, term_c, first_c, accept;

  // ready stays low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  assign inc    = (state_q == RUN) & en;
  assign ready  = armed_q & ((state_q == IDLE) | term_c);
  assign accept = load & ready;
  assign clr    = accept & (state_q == IDLE);
  assign sel    = (mode_q == MODE_SPREAD) ? WIDTH'(bitrev(MAX_W'(cnt), WIDTH)) : cnt;

  unary_frame_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (inc),
    .clr     (clr),
    .cnt     (cnt),
    .term_c  (term_c),
    .first_c (first_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      value_q     <= '0;
      mode_q      <= MODE_THERM;
      sat         <= 1'b0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      mode_q      <= mode_d;
      sat         <= sat_d;
      dout        <= dout_d;
      dout_valid  <= valid_d;
      frame_start <= start_d;
      frame_done  <= done_d;
    end
  end

  // Stalled or idle cycles emit zeros; a load on the final bit chains frames with no gap.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    mode_d  = mode_q;
    sat_d   = sat;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
      end
      RUN: begin
        if (en) begin
          dout_d  = ({1'b0, sel} < value_q);
          valid_d = 1'b1;
          start_d = first_c;
          done_d  = term_c;
          if (term_c) state_d = IDLE;
        end
      end
    endcase
    if (accept) begin
      state_d = RUN;
      value_d = (din > FULL) ? FULL : din;
      mode_d  = mode;
      sat_d   = (din > FULL);
    end
  end

endmodule

// File: tb/tb_unary_stream_gen.sv
// Self-checking bench for unary_stream_gen (WIDTH=4 unit plus a WIDTH=14 pair).
module tb_unary_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, load, mode;
  logic [4:0]  din;
  logic        ready, dout, dout_valid, frame_start, frame_done, sat;

  logic        en_w, load_w, mode_a, mode_b;
  logic [14:0] din_a, din_b;
  logic        ready_a, dout_a, valid_a, fs_a, fd_a, sat_a;
  logic        ready_b, dout_b, valid_b, fs_b, fd_b, sat_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  unary_stream_gen #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din), .mode(mode),
    .ready(ready), .dout(dout), .dout_valid(dout_valid),
    .frame_start(frame_start), .frame_done(frame_done), .sat(sat)
  );

  unary_stream_gen #(.WIDTH(14)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_w), .load(load_w), .din(din_a), .mode(mode_a),
    .ready(ready_a), .dout(dout_a), .dout_valid(valid_a),
    .frame_start(fs_a), .frame_done(fd_a), .sat(sat_a)
  );

  unary_stream_gen #(.WIDTH(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_w), .load(load_w), .din(din_b), .mode(mode_b),
    .ready(ready_b), .dout(dout_b), .dout_valid(valid_b),
    .frame_start(fs_b), .frame_done(fd_b), .sat(sat_b)
  );

  // Reference: bit k of a frame is one when the (optionally reversed) index is below the saturated operand.
  function automatic int rev(input int x, input int w);
    int r = 0;
    int v = x;
    for (int i = 0; i < w; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic exp_bit(input int d, input logic m, input int k, input int w);
    int v;
    int idx;
    v   = (d > (1 << w)) ? (1 << w) : d;
    idx = m ? rev(k, w) : k;
    return (idx < v);
  endfunction

  function automatic logic [15:0] model4(input int d, input logic m);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[4'(k)] = exp_bit(d, m, k, 4);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int d, input logic m, input logic hold);
    din  = 5'(d);
    mode = m;
    load = 1'b1;
    tick();
    if (!hold) load = 1'b0;
  endtask

  // Gather one frame from the small DUT, optionally stalling en after stall_at valid bits.
  task automatic collect(input int stall_at, input int stall_len, input logic drop_load,
                         output logic [15:0] bits, output int nvalid, output int start_at,
                         output int done_at, output int nstart, output int ndone,
                         output int spurious, output int cycles);
    int   left;
    logic stalled;
    bits = '0; nvalid = 0; start_at = -1; done_at = -1; nstart = 0; ndone = 0;
    spurious = 0; cycles = 0; left = 0; stalled = 1'b0;
    while (cycles < 64) begin
      tick();
      cycles++;
      if (dout_valid) begin
        if (nvalid < 16) bits[4'(nvalid)] = dout;
        if (frame_start) begin nstart++; start_at = nvalid; end
        if (frame_done)  begin ndone++;  done_at  = nvalid; end
        nvalid++;
        if (frame_done) break;
        if (nvalid == stall_at && !stalled && stall_len > 0) begin
          en = 1'b0; stalled = 1'b1; left = stall_len;
        end
      end else begin
        if (dout || frame_start || frame_done) spurious++;
        if (left > 0) begin
          left--;
          if (left == 0) en = 1'b1;
        end
      end
    end
    if (drop_load) load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({dout, dout_valid, frame_start, frame_done, sat} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=00000", {dout, dout_valid, frame_start, frame_done, sat});
    end
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b want=1", ready); end
  endtask

  task automatic test_therm();
    logic [15:0] b;
    int nv, sa, da, ns, nd, sp, cy;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL therm_ready_idle got=%b want=1", ready); end
    start_frame(5, 1'b0, 1'b0);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL therm_ready_busy got=%b want=0", ready); end
    collect(0, 0, 1'b0, b, nv, sa, da, ns, nd, sp, cy);
    total++;
    if (b !== model4(5, 1'b0)) begin bad++; $display("FAIL therm_bits got=%h want=%h", b, model4(5, 1'b0)); end
    total++;
    if (ns !== 1 || sa !== 0 || nd !== 1 || da !== 15) begin
      bad++; $display("FAIL therm_pulses start=%0d@%0d done=%0d@%0d want 1@0 1@15", ns, sa, nd, da);
    end
    total++;
    if (cy !== 16 || nv !== 16) begin bad++; $display("FAIL therm_len cycles=%0d valid=%0d want 16/16", cy, nv); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL therm_ready_after got=%b want=1", ready); end
    tick();
    total++;
    if (dout_valid !== 1'b0 || dout !== 1'b0) begin
      bad++; $display("FAIL therm_idle_out valid=%b dout=%b want 0/0", dout_valid, dout);
    end
  endtask

  task automatic test_spread();
    logic [15:0] b;
    int nv, sa, da, ns, nd, sp, cy;
    start_frame(4, 1'b1, 1'b0);
    collect(0, 0, 1'b0, b, nv, sa, da, ns, nd, sp, cy);
    total++;
    if (b !== model4(4, 1'b1)) begin bad++; $display("FAIL spread_bits got=%h want=%h", b, model4(4, 1'b1)); end
    total++;
    if ($countones(b) !== 4) begin bad++; $display("FAIL spread_ones got=%0d want=4", $countones(b)); end
  endtask

  task automatic test_extremes();
    int ds[3] = '{20, 0, 16};
    logic [15:0] b;
    logic m;
    int nv, sa, da, ns, nd, sp, cy;
    foreach (ds[i]) begin
      m = 1'($urandom_range(0, 1));
      start_frame(ds[i], m, 1'b0);
      collect(0, 0, 1'b0, b, nv, sa, da, ns, nd, sp, cy);
      total++;
      if (b !== model4(ds[i], m)) begin
        bad++; $display("FAIL extreme_bits din=%0d got=%h want=%h", ds[i], b, model4(ds[i], m));
      end
      total++;
      if (sat !== (ds[i] > 16)) begin bad++; $display("FAIL extreme_sat din=%0d got=%b", ds[i], sat); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] b;
    int nv, sa, da, ns, nd, sp, cy;
    start_frame(3, 1'b0, 1'b0);
    collect(2, 3, 1'b0, b, nv, sa, da, ns, nd, sp, cy);
    total++;
    if (b !== model4(3, 1'b0)) begin bad++; $display("FAIL stall_bits got=%h want=%h", b, model4(3, 1'b0)); end
    total++;
    if (sp !== 0) begin bad++; $display("FAIL stall_spurious got=%0d want=0", sp); end
    total++;
    if (cy !== 19 || da !== 15) begin bad++; $display("FAIL stall_len cycles=%0d done_at=%0d want 19/15", cy, da); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b1, b2;
    logic m2;
    int nv, sa, da, ns, nd, sp, cy;
    m2 = 1'($urandom_range(0, 1));
    start_frame(7, 1'b0, 1'b1);
    din  = 5'd2;
    mode = m2;
    collect(0, 0, 1'b1, b1, nv, sa, da, ns, nd, sp, cy);
    total++;
    if (b1 !== model4(7, 1'b0) || cy !== 16) begin
      bad++; $display("FAIL b2b_first got=%h cycles=%0d want=%h/16", b1, cy, model4(7, 1'b0));
    end
    collect(0, 0, 1'b0, b2, nv, sa, da, ns, nd, sp, cy);
    total++;
    if (b2 !== model4(2, m2)) begin bad++; $display("FAIL b2b_second got=%h want=%h", b2, model4(2, m2)); end
    total++;
    if (cy !== 16 || sa !== 0 || ns !== 1) begin
      bad++; $display("FAIL b2b_gap cycles=%0d start_at=%0d starts=%0d want 16/0/1", cy, sa, ns);
    end
  endtask

  task automatic test_random();
    logic [15:0] b;
    logic m;
    int d, st, sl;
    int nv, sa, da, ns, nd, sp, cy;
    for (int f = 0; f < 8; f++) begin
      d  = int'($urandom_range(0, 31));
      m  = 1'($urandom_range(0, 1));
      st = int'($urandom_range(1, 14));
      sl = int'($urandom_range(0, 3));
      start_frame(d, m, 1'b0);
      din  = 5'($urandom);
      mode = ~m;
      collect(st, sl, 1'b0, b, nv, sa, da, ns, nd, sp, cy);
      total++;
      if (b !== model4(d, m) || cy !== 16 + sl || sp !== 0 || sat !== (d > 16)) begin
        bad++;
        $display("FAIL random_frame din=%0d mode=%b got=%h want=%h cycles=%0d want=%0d spur=%0d sat=%b",
                 d, m, b, model4(d, m), cy, 16 + sl, sp, sat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    start_frame(18, 1'b0, 1'b0);
    repeat (9) tick();
    total++;
    if (dout !== 1'b1 || sat !== 1'b1 || dout_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_pre dout=%b sat=%b valid=%b want 1/1/1", dout, sat, dout_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({dout, dout_valid, frame_start, frame_done, sat, ready} !== 6'b0) begin
      bad++; $display("FAIL midrst_async got=%b want=000000", {dout, dout_valid, frame_start, frame_done, sat, ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", ready); end
    extra = 0;
    repeat (20) begin
      if (dout_valid || frame_done || dout) extra++;
      tick();
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL midrst_residue got=%0d want=0", extra); end
  endtask

  task automatic test_full_width();
    int va, vb, oa, ob, ma, mb, da, db, cyc;
    mode_a = 1'($urandom_range(0, 1));
    mode_b = 1'($urandom_range(0, 1));
    din_a  = 15'd4096;
    din_b  = 15'd8193;
    total++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      bad++; $display("FAIL wide_ready got=%b%b want=11", ready_a, ready_b);
    end
    load_w = 1'b1;
    tick();
    load_w = 1'b0;
    din_a  = 15'd0;
    din_b  = 15'd0;
    va = 0; vb = 0; oa = 0; ob = 0; ma = 0; mb = 0; da = 0; db = 0; cyc = 0;
    while ((da == 0 || db == 0) && cyc < 16500) begin
      tick();
      cyc++;
      if (valid_a) begin
        if (dout_a) oa++;
        if (dout_a !== exp_bit(4096, mode_a, va, 14)) ma++;
        va++;
        if (fd_a) da++;
      end
      if (valid_b) begin
        if (dout_b) ob++;
        if (dout_b !== exp_bit(8193, mode_b, vb, 14)) mb++;
        vb++;
        if (fd_b) db++;
      end
    end
    total++;
    if (oa !== 4096 || ob !== 8193) begin bad++; $display("FAIL wide_ones a=%0d b=%0d want 4096/8193", oa, ob); end
    total++;
    if (ma !== 0 || mb !== 0) begin bad++; $display("FAIL wide_pattern bad_bits a=%0d b=%0d want 0/0", ma, mb); end
    total++;
    if (va !== 16384 || vb !== 16384 || da !== 1 || db !== 1) begin
      bad++; $display("FAIL wide_frame valid=%0d/%0d done=%0d/%0d want 16384 and 1", va, vb, da, db);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0; din = '0; mode = 1'b0;
    en_w = 1'b1; load_w = 1'b0; din_a = '0; din_b = '0; mode_a = 1'b0; mode_b = 1'b0;
    test_reset();
    test_therm();
    test_spread();
    test_extremes();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_full_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
